seg7_display_driver: RTL and testbench

- Output-side counterpart to the push-button input path: turns a clean 8-bit value from the CPU output register into a multiplexed 4-digit 7-segment display.
- Captures a value on a load strobe and converts it to BCD with a sequential shift-add-3 FSM.
- Time-multiplexes sign/hundreds/tens/ones digits onto shared active-low segment lines.
- Sits between the CPU output register and the board display pins.

---
 rtl/seg7_display_driver.sv | 173 +++++++++++++++++
 tb/tb_seg7_display_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_driver.sv
// Loads an 8-bit value, converts it to BCD (shift-add-3) and scans sign/hundreds/tens/ones onto a 4-digit display; SEG7_HEX_MODE_EN adds hex display.
// Latency: busy high for 9 cycles after load; new digits reach seg 10 cycles after the load edge.
// Backpressure: load is dropped while busy; scanning never stalls and shows the previous value until commit.
module seg7_display_driver #(
   parameter logic [15:0] SCAN_DIV = 16'd50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] value,
   input  logic       load,
   input  logic       signed_mode,
`ifdef SEG7_HEX_MODE_EN
   input  logic       hex_mode,
`endif
   output logic       busy,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] MINUS = 7'b0111111;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t      state;
   logic [7:0]  mag;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  bit_cnt;
   logic        neg_cap;
   logic        hex_cap;
   logic        hex_req;
   logic [3:0]  disp_o;
   logic [3:0]  disp_t;
   logic [3:0]  disp_h;
   logic        disp_neg;
   logic        disp_hex;
   logic [15:0] prescaler;
   logic [1:0]  scan_idx;
   logic [6:0]  dig_seg;
   logic [3:0]  dig_an;
   logic        dig_dp;

`ifdef SEG7_HEX_MODE_EN
   assign hex_req = hex_mode;
`else
   assign hex_req = 1'b0;
`endif

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b1000110;
         4'hD:    return 7'b0100001;
         4'hE:    return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [11:0] add3(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Hex mode skips the adjust so the shift register ends up holding the raw byte.
   assign bcd_adj = hex_cap ? bcd : add3(bcd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         mag      <= 8'd0;
         bcd      <= 12'd0;
         bit_cnt  <= 3'd0;
         neg_cap  <= 1'b0;
         hex_cap  <= 1'b0;
         disp_o   <= 4'd0;
         disp_t   <= 4'd0;
         disp_h   <= 4'd0;
         disp_neg <= 1'b0;
         disp_hex <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  if (signed_mode && value[7] && !hex_req) begin
                     mag     <= 8'(~value + 8'd1);
                     neg_cap <= 1'b1;
                  end else begin
                     mag     <= value;
                     neg_cap <= 1'b0;
                  end
                  hex_cap <= hex_req;
                  bcd     <= 12'd0;
                  bit_cnt <= 3'd0;
                  busy    <= 1'b1;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               bcd     <= {bcd_adj[10:0], mag[7]};
               mag     <= {mag[6:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= COMMIT;
            end
            COMMIT: begin
               disp_o   <= bcd[3:0];
               disp_t   <= bcd[7:4];
               disp_h   <= bcd[11:8];
               disp_neg <= neg_cap;
               disp_hex <= hex_cap;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Leading-zero blanking; blank digits keep their enable so the scan duty stays even.
   always_comb begin
      dig_seg = BLANK;
      dig_dp  = 1'b1;
      dig_an  = 4'b1111;
      dig_an[scan_idx] = 1'b0;
      case (scan_idx)
         2'd0: begin
            dig_seg = seg_code(disp_o);
            dig_dp  = ~disp_hex;
         end
         2'd1: if (disp_hex || disp_h != 4'd0 || disp_t != 4'd0) dig_seg = seg_code(disp_t);
         2'd2: if (!disp_hex && disp_h != 4'd0) dig_seg = seg_code(disp_h);
         default: if (disp_neg) dig_seg = MINUS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= 16'd0;
         scan_idx  <= 2'd0;
         an        <= 4'b1111;
         seg       <= BLANK;
         dp        <= 1'b1;
      end else begin
         if (prescaler == SCAN_DIV - 16'd1) begin
            prescaler <= 16'd0;
            scan_idx  <= scan_idx + 2'd1;
         end else begin
            prescaler <= prescaler + 16'd1;
         end
         an  <= dig_an;
         seg <= dig_seg;
         dp  <= dig_dp;
      end
   end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboarded bench for seg7_display_driver with SCAN_DIV=4.
`timescale 1ns/1ps
module tb_seg7_display_driver;

   localparam logic [15:0] SCAN_DIV = 16'd4;
   localparam logic [6:0]  BL = 7'b1111111;
   localparam logic [6:0]  MI = 7'b0111111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] value = 8'd0;
   logic       load = 1'b0;
   logic       signed_mode = 1'b0;
`ifdef SEG7_HEX_MODE_EN
   logic       hex_mode = 1'b0;
`endif
   logic       busy;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   seg7_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .value(value),
      .load(load),
      .signed_mode(signed_mode),
`ifdef SEG7_HEX_MODE_EN
      .hex_mode(hex_mode),
`endif
      .busy(busy),
      .seg(seg),
      .dp(dp),
      .an(an)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic push_display(input logic [6:0] sgn, input logic [6:0] h,
                               input logic [6:0] t, input logic [6:0] o);
      exp_q.push_back('{an: 4'b1110, seg: o,   dp: 1'b1});
      exp_q.push_back('{an: 4'b1101, seg: t,   dp: 1'b1});
      exp_q.push_back('{an: 4'b1011, seg: h,   dp: 1'b1});
      exp_q.push_back('{an: 4'b0111, seg: sgn, dp: 1'b1});
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_digits_seen"}, 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   // late_cyc > 0 issues a second load sampled at that edge while busy.
   task automatic do_load(input string name, input logic [7:0] v, input logic sm,
                          input int late_cyc, input logic [7:0] late_v);
      @(negedge clk);
      value = v;
      signed_mode = sm;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      value = 8'hAA;
      signed_mode = 1'b0;
      check($sformatf("%s_busy_c1", name), 16'(busy), 16'd1);
      for (int k = 2; k <= 10; k++) begin
         if (k - 1 == late_cyc) begin
            value = late_v;
            load = 1'b1;
         end
         @(negedge clk);
         load = 1'b0;
         check($sformatf("%s_busy_c%0d", name, k), 16'(busy), 16'(k <= 9 ? 1 : 0));
      end
      @(negedge clk);
   endtask

   // Monitor: every scan step is an output event.
   logic [3:0] prev_an = 4'b1111;
   int         gap = 0;
   bit         gap_ok = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_an = 4'b1111;
         gap = 0;
         gap_ok = 1'b0;
      end else begin
         gap++;
         if (an != prev_an) begin
            check("an_onehot", 16'($countones(~an)), 16'd1);
            if (gap_ok) check("scan_period", 16'(gap), SCAN_DIV);
            gap_ok = 1'b1;
            gap = 0;
            if (exp_q.size() > 0 && exp_q[0].an == an) begin
               e = exp_q.pop_front();
               check($sformatf("seg_an%b", an), 16'(seg), 16'(e.seg));
               check($sformatf("dp_an%b", an), 16'(dp), 16'(e.dp));
            end
            prev_an = an;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_an", 16'(an), 16'h000F);
      check("rst_seg", 16'(seg), 16'(BL));
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_dp", 16'(dp), 16'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_display(BL, BL, BL, 7'b1000000);
      wait_drain("reset_zero");

      do_load("u123", 8'd123, 1'b0, 0, 8'd0);
      push_display(BL, 7'b1111001, 7'b0100100, 7'b0110000);
      wait_drain("u123");

      do_load("s80", 8'h80, 1'b1, 0, 8'd0);
      push_display(MI, 7'b1111001, 7'b0100100, 7'b0000000);
      wait_drain("s80");

      do_load("sff", 8'hFF, 1'b1, 0, 8'd0);
      push_display(MI, BL, BL, 7'b1111001);
      wait_drain("sff");

      do_load("u7_drop200", 8'd7, 1'b0, 3, 8'd200);
      push_display(BL, BL, BL, 7'b1111000);
      wait_drain("u7_drop200");

      // Reset in the middle of a conversion of 45.
      @(negedge clk);
      value = 8'd45;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_busy_before_rst", 16'(busy), 16'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_an", 16'(an), 16'h000F);
      check("mid_rst_seg", 16'(seg), 16'(BL));
      check("mid_rst_busy", 16'(busy), 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_display(BL, BL, BL, 7'b1000000);
      wait_drain("after_mid_rst");
      check("after_mid_rst_busy", 16'(busy), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
